// File: rtl/noc_injector.sv
// noc_injector: turns a word stream into HEAD/BODY/TAIL flits for a
// credit-flow-controlled link. A small FIFO decouples the source from the
// link. A packet of N words leaves as one HEAD flit carrying the
// destination, then N-1 BODY flits, then a TAIL flit. Each flit spends one
// downstream credit.
module noc_injector #(
  parameter int DATA_W     = 7,
  parameter int DEST_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DEST_W-1:0] req_dest,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_last,
  input  logic              credit_in,
  output logic              out_enable,
  output logic [1:0]        out_kind,
  output logic [DATA_W-1:0] out_data,
  output logic              credit_err,
  output logic [15:0]       flit_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CRED_W = $clog2(CREDITS + 1);

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [0:0] {IDLE, BODY} state_t;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_HEAD = 2'b01,
    KIND_BODY = 2'b10,
    KIND_TAIL = 2'b11
  } kind_t;

  entry_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CRED_W-1:0] credits;
  logic              first_word;
  logic [DEST_W-1:0] pkt_dest;
  state_t            state, state_next;
  kind_t             kind_q, kind_next;
  logic [DATA_W-1:0] data_next;
  logic              push, pop, emit;
  entry_t            head;
  entry_t            wr_entry;

  assign req_ready = (count < CNT_W'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign head      = mem[rd_ptr];
  assign out_kind  = kind_q;

  // Later words of a packet reuse the destination captured with its first word.
  assign wr_entry.dest = first_word ? req_dest : pkt_dest;
  assign wr_entry.last = req_last;
  assign wr_entry.data = req_data;

  // Buffer storage: written on accept only.
  // NOTE: the storage array has no reset; count/pointers alone define validity,
  // so clearing it would just cost a wide reset network.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // FIFO pointers, occupancy and packet-start tracking.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      first_word <= 1'b1;
      pkt_dest   <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        first_word <= req_last;
        if (first_word) pkt_dest <= req_dest;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Emit decision: HEAD without popping in IDLE, then one entry per flit in BODY.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    kind_next  = KIND_NONE;
    data_next  = '0;
    pop        = 1'b0;
    emit       = 1'b0;
    if ((count != '0) && (credits != '0)) begin
      emit = 1'b1;
      if (state == IDLE) begin
        kind_next  = KIND_HEAD;
        data_next  = DATA_W'(head.dest);
        state_next = BODY;
      end else begin
        pop       = 1'b1;
        data_next = head.data;
        if (head.last) begin
          kind_next  = KIND_TAIL;
          state_next = IDLE;
        end else begin
          kind_next  = KIND_BODY;
        end
      end
    end
  end

  // FSM state register; reset abandons any partial packet.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Registered link outputs and the wrapping flit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_enable <= 1'b0;
      kind_q     <= KIND_NONE;
      out_data   <= '0;
      flit_count <= '0;
    end else begin
      out_enable <= emit;
      kind_q     <= kind_next;
      out_data   <= data_next;
      if (emit) flit_count <= flit_count + 16'd1;
    end
  end

  // Credit counter; a return with the counter already full is an overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits    <= CRED_W'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      case ({emit, credit_in})
        2'b10: credits <= credits - CRED_W'(1);
        2'b01: begin
          if (credits == CRED_W'(CREDITS)) credit_err <= 1'b1;
          else                             credits    <= credits + CRED_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_injector.sv
// Testbench for noc_injector: a per-cycle vector table followed by
// hand-written sequences for stalls, back-pressure and credit timing.
module tb_noc_injector;

  localparam int DW = 7;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [TW-1:0] req_dest;
  logic [DW-1:0] req_data;
  logic          req_last;
  logic          credit_in;
  logic          out_enable;
  logic [1:0]    out_kind;
  logic [DW-1:0] out_data;
  logic          credit_err;
  logic [15:0]   flit_count;

  int n_vec = 0;
  int n_err = 0;

  noc_injector #(.DATA_W(DW), .DEST_W(TW), .FIFO_DEPTH(4), .CREDITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest   (req_dest),
    .req_data   (req_data),
    .req_last   (req_last),
    .credit_in  (credit_in),
    .out_enable (out_enable),
    .out_kind   (out_kind),
    .out_data   (out_data),
    .credit_err (credit_err),
    .flit_count (flit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          valid;
    logic [TW-1:0] dest;
    logic [DW-1:0] data;
    logic          last;
    logic          cin;
    logic          rdy;
    logic          oe;
    logic [1:0]    kind;
    logic [DW-1:0] odata;
    logic          cerr;
    logic [15:0]   fcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic [TW-1:0] d,
                              input logic [DW-1:0] dat, input logic l, input logic c,
                              input logic rdy, input logic oe, input logic [1:0] k,
                              input logic [DW-1:0] od, input logic ce, input logic [15:0] fc);
    vec_t t;
    t.rst = r;   t.valid = v; t.dest = d;  t.data = dat; t.last = l; t.cin = c;
    t.rdy = rdy; t.oe = oe;   t.kind = k;  t.odata = od; t.cerr = ce; t.fcnt = fc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [TW-1:0] d,
                       input logic [DW-1:0] dat, input logic l, input logic c);
    rst = r; req_valid = v; req_dest = d; req_data = dat; req_last = l; credit_in = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    logic rdy_pre;
    logic [1:0]    kinds [8];
    logic [DW-1:0] datas [8];

    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Columns: rst valid dest data last cin | ready oe kind out_data cerr flit_count
    vecs.push_back(mk(1,0,4'h0,7'h00,0,0, 1,0,2'd0,7'h00,0,16'd0));   // reset
    // three-word packet, dest 3
    vecs.push_back(mk(0,1,4'h3,7'h11,0,0, 1,0,2'd0,7'h00,0,16'd0));
    vecs.push_back(mk(0,1,4'hF,7'h22,0,0, 1,1,2'd1,7'h03,0,16'd1));
    vecs.push_back(mk(0,1,4'hF,7'h33,1,0, 1,1,2'd2,7'h11,0,16'd2));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd2,7'h22,0,16'd3));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd3,7'h33,0,16'd4));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,0,2'd0,7'h00,0,16'd4));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,0,4'h0,7'h00,0,1, 1,0,2'd0,7'h00,0,16'd4));
    // single-word packet, dest 9
    vecs.push_back(mk(0,1,4'h9,7'h55,1,0, 1,0,2'd0,7'h00,0,16'd4));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd1,7'h09,0,16'd5));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd3,7'h55,0,16'd6));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,0,2'd0,7'h00,0,16'd6));
    // back in IDLE: a second single-word packet starts with HEAD again
    vecs.push_back(mk(0,1,4'hA,7'h7F,1,0, 1,0,2'd0,7'h00,0,16'd6));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd1,7'h0A,0,16'd7));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd3,7'h7F,0,16'd8));
    // refill credits to 4, then one surplus return sets credit_err
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,0,4'h0,7'h00,0,1, 1,0,2'd0,7'h00,0,16'd8));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,1, 1,0,2'd0,7'h00,1,16'd8));
    // credits must still be 4: exactly four flits, then a stall
    vecs.push_back(mk(0,1,4'h1,7'h01,1,0, 1,0,2'd0,7'h00,1,16'd8));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd1,7'h01,1,16'd9));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd3,7'h01,1,16'd10));
    vecs.push_back(mk(0,1,4'h2,7'h02,1,0, 1,0,2'd0,7'h00,1,16'd10));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd1,7'h02,1,16'd11));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd3,7'h02,1,16'd12));
    vecs.push_back(mk(0,1,4'h3,7'h03,1,0, 1,0,2'd0,7'h00,1,16'd12));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,0,2'd0,7'h00,1,16'd12));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,0,2'd0,7'h00,1,16'd12));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,1, 1,0,2'd0,7'h00,1,16'd12));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd1,7'h03,1,16'd13));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,0,2'd0,7'h00,1,16'd13));
    // reset clears credit_err; then reset mid-packet after the first BODY
    vecs.push_back(mk(1,0,4'h0,7'h00,0,0, 1,0,2'd0,7'h00,0,16'd0));
    vecs.push_back(mk(0,1,4'h3,7'h11,0,0, 1,0,2'd0,7'h00,0,16'd0));
    vecs.push_back(mk(0,1,4'hF,7'h22,0,0, 1,1,2'd1,7'h03,0,16'd1));
    vecs.push_back(mk(0,1,4'hF,7'h33,1,0, 1,1,2'd2,7'h11,0,16'd2));
    vecs.push_back(mk(1,0,4'h0,7'h00,0,0, 1,0,2'd0,7'h00,0,16'd0));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,0,2'd0,7'h00,0,16'd0));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,0,2'd0,7'h00,0,16'd0));
    // fresh packet after reset latches its own destination
    vecs.push_back(mk(0,1,4'hC,7'h44,1,0, 1,0,2'd0,7'h00,0,16'd0));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd1,7'h0C,0,16'd1));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,1,2'd3,7'h44,0,16'd2));
    vecs.push_back(mk(0,0,4'h0,7'h00,0,0, 1,0,2'd0,7'h00,0,16'd2));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].dest, vecs[i].data, vecs[i].last, vecs[i].cin);
      tick();
      check($sformatf("v%0d.ready", i), 32'(req_ready),  32'(vecs[i].rdy));
      check($sformatf("v%0d.oe", i),    32'(out_enable), 32'(vecs[i].oe));
      check($sformatf("v%0d.kind", i),  32'(out_kind),   32'(vecs[i].kind));
      check($sformatf("v%0d.data", i),  32'(out_data),   32'(vecs[i].odata));
      check($sformatf("v%0d.cerr", i),  32'(credit_err), 32'(vecs[i].cerr));
      check($sformatf("v%0d.fcnt", i),  32'(flit_count), 32'(vecs[i].fcnt));
    end

    // Emit and credit return on the same edge leave credits unchanged (4 -> 4 -> 3).
    do_reset();
    drive(1'b0, 1'b1, 4'h5, 7'h0C, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    check("same_edge.head_oe",   32'(out_enable), 32'd1);
    check("same_edge.head_data", 32'(out_data),   32'h05);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    check("same_edge.tail_kind", 32'(out_kind),   32'd3);
    check("same_edge.no_err",    32'(credit_err), 32'd0);
    n = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 2) drive(1'b0, 1'b1, 4'(i + 1), 7'(i + 1), 1'b1, 1'b0);
      else       drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      if (out_enable) n++;
    end
    check("same_edge.flits_on_3_credits", 32'(n), 32'd3);

    // Six-word packet with no returns: HEAD + 3 BODY, then one more per credit.
    do_reset();
    acc = 0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (acc < 6) drive(1'b0, 1'b1, 4'h7, 7'(8'h60 + acc), (acc == 5), 1'b0);
      else         drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      rdy_pre = req_ready;
      tick();
      if (req_valid && rdy_pre) acc++;
      if (out_enable) begin
        if (n < 8) begin
          kinds[n] = out_kind;
          datas[n] = out_data;
        end
        n++;
      end
    end
    check("six_word.accepted", 32'(acc), 32'd6);
    check("six_word.flits",    32'(n),   32'd4);
    check("six_word.k0", 32'(kinds[0]), 32'd1);
    check("six_word.d0", 32'(datas[0]), 32'h07);
    check("six_word.k1", 32'(kinds[1]), 32'd2);
    check("six_word.d1", 32'(datas[1]), 32'h60);
    check("six_word.d2", 32'(datas[2]), 32'h61);
    check("six_word.k3", 32'(kinds[3]), 32'd2);
    check("six_word.d3", 32'(datas[3]), 32'h62);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    n = 0;
    for (int i = 0; i < 11; i++) begin
      if (out_enable) begin
        kinds[0] = out_kind;
        datas[0] = out_data;
        n++;
      end
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      tick();
    end
    check("six_word.extra_flits", 32'(n),        32'd1);
    check("six_word.extra_kind",  32'(kinds[0]), 32'd2);
    check("six_word.extra_data",  32'(datas[0]), 32'h63);

    // Back-pressure: drain all credits, then hold req_valid until the FIFO fills.
    do_reset();
    drive(1'b0, 1'b1, 4'h1, 7'h01, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 4'h2, 7'h02, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check("bp.drained_fcnt", 32'(flit_count), 32'd4);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 4'h6, 7'(8'h10 + acc), 1'b0, 1'b0);
      rdy_pre = req_ready;
      tick();
      if (rdy_pre) acc++;
    end
    check("bp.accepts",    32'(acc),        32'd4);
    check("bp.ready_full", 32'(req_ready),  32'd0);
    check("bp.stalled_oe", 32'(out_enable), 32'd0);
    drive(1'b0, 1'b1, 4'h6, 7'h14, 1'b0, 1'b1);
    tick();
    check("bp.credit_ready", 32'(req_ready),  32'd0);
    check("bp.credit_oe",    32'(out_enable), 32'd0);
    tick();
    check("bp.head_kind",  32'(out_kind),  32'd1);
    check("bp.head_data",  32'(out_data),  32'h06);
    check("bp.head_ready", 32'(req_ready), 32'd0);
    drive(1'b0, 1'b1, 4'h6, 7'h14, 1'b0, 1'b0);
    tick();
    check("bp.pop_kind",  32'(out_kind),  32'd2);
    check("bp.pop_data",  32'(out_data),  32'h10);
    check("bp.pop_ready", 32'(req_ready), 32'd1);
    tick();
    check("bp.refill_ready", 32'(req_ready),  32'd0);
    check("bp.no_credit_oe", 32'(out_enable), 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
